// File: rtl/proc_mem_ctrl.sv
// Processor-to-SRAM access controller.
// Accepts one read or write per request, runs a single SRAM strobe, waits out
// the fixed SRAM latency, then pulses mem_resp once. A request that stays high
// after completion is parked in HOLD so it never triggers a second access.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request with exactly one of read_req/write_req
// ACCESS | sram_ce strobe cycle, wait counter loaded with latency-1
// WAIT   | counting down the remaining SRAM latency
// RESP   | mem_resp pulse; read data already captured on entry
// HOLD   | waiting for the processor to drop its request
module proc_mem_ctrl #(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read_req,
    input  logic        write_req,
    input  logic [13:0] addrout,
    input  logic [15:0] datatomem,
    output logic [15:0] datafrommem,
    output logic        mem_resp,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [13:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        err_both
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        HOLD
    } state_t;

    localparam logic [2:0] RD_LOAD = 3'(RD_LAT - 1);
    localparam logic [2:0] WR_LOAD = 3'(WR_LAT - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] cnt;
    logic       is_wr;
    logic       accept;
    logic       both;
    logic [2:0] load_val;

    assign accept   = cs && (read_req ^ write_req);
    assign both     = cs && read_req && write_req;
    assign load_val = is_wr ? WR_LOAD : RD_LOAD;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and strobe outputs.
    always_comb begin
        state_next = state;
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        mem_resp   = 1'b0;
        case (state)
            IDLE: begin
                if (both) begin
                    state_next = HOLD;
                end else if (accept) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                sram_ce    = 1'b1;
                sram_we    = is_wr;
                state_next = (load_val == 3'd0) ? RESP : WAIT;
            end
            WAIT: begin
                // cnt==1 means this cycle's decrement lands on zero.
                if (cnt <= 3'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                mem_resp   = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (!cs || (!read_req && !write_req)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency counter, read data and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 3'd0;
            is_wr       <= 1'b0;
            sram_addr   <= 14'h0000;
            sram_wdata  <= 16'h0000;
            datafrommem <= 16'h0000;
            err_both    <= 1'b0;
        end else begin
            if (state == IDLE && accept && !both) begin
                sram_addr  <= addrout;
                sram_wdata <= datatomem;
                is_wr      <= write_req;
            end
            if (state == IDLE && both) begin
                err_both <= 1'b1;
            end
            if (state == ACCESS) begin
                cnt <= load_val;
            end else if (state == WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            // Read data is sampled on the edge that enters RESP.
            if (state != RESP && state_next == RESP && !is_wr) begin
                datafrommem <= sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_proc_mem_ctrl.sv
// Directed bench: default-latency controller and an RD_LAT=1 build share the
// processor inputs; each has its own SRAM model with exact read latency.
module tb_proc_mem_ctrl;

    localparam int RD_A = 2;
    localparam int WR_A = 1;
    localparam int RD_B = 1;
    localparam int WR_B = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        read_req;
    logic        write_req;
    logic [13:0] addrout;
    logic [15:0] datatomem;

    logic [15:0] a_dfm, b_dfm;
    logic        a_resp, b_resp;
    logic        a_ce, b_ce;
    logic        a_we, b_we;
    logic [13:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [15:0] a_rdata, b_rdata;
    logic        a_err, b_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    proc_mem_ctrl #(.RD_LAT(RD_A), .WR_LAT(WR_A)) dut_a (
        .clk(clk), .reset(reset), .cs(cs), .read_req(read_req), .write_req(write_req),
        .addrout(addrout), .datatomem(datatomem), .datafrommem(a_dfm), .mem_resp(a_resp),
        .sram_ce(a_ce), .sram_we(a_we), .sram_addr(a_addr), .sram_wdata(a_wdata),
        .sram_rdata(a_rdata), .err_both(a_err)
    );

    proc_mem_ctrl #(.RD_LAT(RD_B), .WR_LAT(WR_B)) dut_b (
        .clk(clk), .reset(reset), .cs(cs), .read_req(read_req), .write_req(write_req),
        .addrout(addrout), .datatomem(datatomem), .datafrommem(b_dfm), .mem_resp(b_resp),
        .sram_ce(b_ce), .sram_we(b_we), .sram_addr(b_addr), .sram_wdata(b_wdata),
        .sram_rdata(b_rdata), .err_both(b_err)
    );

    // SRAM models: read data is valid only in the cycle RD_LAT-1 after the strobe.
    logic [15:0] mem_a [0:16383];
    logic [15:0] mem_b [0:16383];
    logic [2:0]  age_a = 3'd0, age_b = 3'd0;
    logic        act_a = 1'b0, act_b = 1'b0;
    logic [13:0] raddr_a = 14'h0, raddr_b = 14'h0;

    always @(posedge clk) begin
        if (a_ce && a_we) mem_a[a_addr] <= a_wdata;
        if (a_ce && !a_we) begin
            act_a <= 1'b1; age_a <= 3'd1; raddr_a <= a_addr;
        end else if (act_a) begin
            age_a <= age_a + 3'd1;
            if (age_a == 3'd7) act_a <= 1'b0;
        end
        if (b_ce && b_we) mem_b[b_addr] <= b_wdata;
        if (b_ce && !b_we) begin
            act_b <= 1'b1; age_b <= 3'd1; raddr_b <= b_addr;
        end else if (act_b) begin
            age_b <= age_b + 3'd1;
            if (age_b == 3'd7) act_b <= 1'b0;
        end
    end

    always_comb begin
        a_rdata = 16'hDEAD;
        if (a_ce && !a_we && RD_A == 1) a_rdata = mem_a[a_addr];
        else if (act_a && int'(age_a) == RD_A - 1) a_rdata = mem_a[raddr_a];
        b_rdata = 16'hDEAD;
        if (b_ce && !b_we && RD_B == 1) b_rdata = mem_b[b_addr];
        else if (act_b && int'(age_b) == RD_B - 1) b_rdata = mem_b[raddr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          ce_a, ce_b, rc_a, rc_b, ridx_a, ridx_b;
    logic        cwe_a, cwe_b;
    logic [13:0] caddr_a, caddr_b;
    logic [15:0] cwd_a, cwd_b;

    task automatic sample(input int idx);
        if (a_ce) begin ce_a++; cwe_a = a_we; caddr_a = a_addr; cwd_a = a_wdata; end
        if (b_ce) begin ce_b++; cwe_b = b_we; caddr_b = b_addr; cwd_b = b_wdata; end
        if (a_resp) begin rc_a++; ridx_a = idx; end
        if (b_resp) begin rc_b++; ridx_b = idx; end
    endtask

    task automatic clear_counts();
        ce_a = 0; ce_b = 0; rc_a = 0; rc_b = 0; ridx_a = -1; ridx_b = -1;
        cwe_a = 1'b0; cwe_b = 1'b0; caddr_a = '0; caddr_b = '0; cwd_a = '0; cwd_b = '0;
    endtask

    // Request applied before edge 0; observation i is taken i negedges later.
    // Inputs are scrambled right after acceptance to show they are captured.
    task automatic run_access(input logic wr, input logic [13:0] a, input logic [15:0] d,
                              input int hold);
        clear_counts();
        cs = 1'b1; read_req = !wr; write_req = wr; addrout = a; datatomem = d;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            sample(i);
            if (i == 1) begin addrout = ~a; datatomem = ~d; end
        end
        cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
        for (int i = hold + 1; i <= hold + 2; i++) begin
            @(negedge clk);
            sample(i);
        end
    endtask

    task automatic check_access(input string tag, input logic wr, input logic [13:0] a,
                                input logic [15:0] d, input logic [15:0] exp_q);
        check({tag, "_ce_a"}, ce_a, 1);
        check({tag, "_ce_b"}, ce_b, 1);
        check({tag, "_we_a"}, cwe_a, wr);
        check({tag, "_we_b"}, cwe_b, wr);
        check({tag, "_addr_a"}, caddr_a, a);
        check({tag, "_addr_b"}, caddr_b, a);
        if (wr) begin
            check({tag, "_wdata_a"}, cwd_a, d);
            check({tag, "_wdata_b"}, cwd_b, d);
        end
        check({tag, "_resps_a"}, rc_a, 1);
        check({tag, "_resps_b"}, rc_b, 1);
        check({tag, "_lat_a"}, ridx_a, 1 + (wr ? WR_A : RD_A));
        check({tag, "_lat_b"}, ridx_b, 1 + (wr ? WR_B : RD_B));
        check({tag, "_dfm_a"}, a_dfm, exp_q);
        check({tag, "_dfm_b"}, b_dfm, exp_q);
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
        addrout = '0; datatomem = '0;
        #1;
        check("rst_dfm", a_dfm, 16'h0000);
        check("rst_resp", a_resp, 0);
        check("rst_ce", a_ce, 0);
        check("rst_we", a_we, 0);
        check("rst_addr", a_addr, 14'h0);
        check("rst_wdata", a_wdata, 16'h0);
        check("rst_err", a_err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        run_access(1'b1, 14'h0123, 16'hBEEF, 6);
        check_access("wr0123", 1'b1, 14'h0123, 16'hBEEF, 16'h0000);
        run_access(1'b0, 14'h0123, 16'h0000, 6);
        check_access("rd0123", 1'b0, 14'h0123, 16'hBEEF, 16'hBEEF);
        run_access(1'b1, 14'h3FFF, 16'h1234, 6);
        check_access("wr3fff", 1'b1, 14'h3FFF, 16'h1234, 16'hBEEF);
        run_access(1'b0, 14'h3FFF, 16'h0000, 10);
        check_access("rd3fff_hold", 1'b0, 14'h3FFF, 16'h1234, 16'h1234);
        run_access(1'b1, 14'h0000, 16'h5678, 4);
        check_access("wr0000", 1'b1, 14'h0000, 16'h5678, 16'h1234);
        run_access(1'b0, 14'h0000, 16'h0000, 5);
        check_access("rd0000", 1'b0, 14'h0000, 16'h5678, 16'h5678);

        // Both requests at once: no access, sticky error.
        clear_counts();
        cs = 1'b1; read_req = 1'b1; write_req = 1'b1; addrout = 14'h0123;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            sample(i);
        end
        cs = 1'b0; read_req = 1'b0; write_req = 1'b0;
        @(negedge clk);
        sample(6);
        check("both_ce_a", ce_a, 0);
        check("both_ce_b", ce_b, 0);
        check("both_resp_a", rc_a, 0);
        check("both_resp_b", rc_b, 0);
        check("both_err_a", a_err, 1);
        check("both_err_b", b_err, 1);
        run_access(1'b0, 14'h0123, 16'h0000, 6);
        check_access("rd_after_err", 1'b0, 14'h0123, 16'hBEEF, 16'hBEEF);
        check("err_sticky", a_err, 1);

        // Reset while dut_a is in WAIT of a read.
        clear_counts();
        cs = 1'b1; read_req = 1'b1; addrout = 14'h3FFF;
        @(negedge clk);
        sample(1);
        @(negedge clk);
        check("abort_no_resp_yet", a_resp, 0);
        reset = 1'b1;
        #1;
        check("abort_dfm", a_dfm, 16'h0000);
        check("abort_addr", a_addr, 14'h0);
        check("abort_ce", a_ce, 0);
        check("abort_err", a_err, 0);
        cs = 1'b0; read_req = 1'b0;
        rc_a = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a_resp) rc_a++;
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (a_resp) rc_a++;
        end
        check("abort_resp_count", rc_a, 0);
        run_access(1'b0, 14'h0123, 16'h0000, 6);
        check_access("rd_after_rst", 1'b0, 14'h0123, 16'hBEEF, 16'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
